// File: rtl/simon_button_conditioner.sv
// Input stage for the Simon Says game: synchronizes and debounces four push-buttons,
// then turns each clean single-button press into one valid/ready event.
module simon_button_conditioner #(
  parameter int DEBOUNCE_TICKS = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] button,
  input  logic       clear,
  input  logic       press_ready,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic [3:0] press_onehot,
  output logic [3:0] held,
  output logic       chord_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       held_d;
  logic [CNT_W-1:0] cnt [4];

  logic [3:0] rise;
  logic [1:0] rise_code;
  logic       good;
  logic       chord;
  logic       load;
  logic       drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= button;
      sync_b <= sync_a;
    end
  end

  // A counter only survives while its input disagrees with the stable level;
  // any agreeing cycle, ticked or not, restarts the qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held   <= '0;
      held_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      held_d <= held;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == held[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            held[i] <= ~held[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rise      = held & ~held_d;
    rise_code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) rise_code = 2'(i);
    end
    // A press is good only if it is the sole button down after the rise.
    good  = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0) && ((held & ~rise) == 4'd0);
    chord = (rise != 4'd0) && !good;
    load  = good && (!press_valid || press_ready);
    drop  = good && press_valid && !press_ready;
  end

  // clear takes priority over both a new load and an overrun set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_valid <= 1'b0;
      press_code  <= 2'd0;
      chord_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      chord_err <= chord;
      if (clear) begin
        press_valid <= 1'b0;
        overrun     <= 1'b0;
      end else begin
        if (load) begin
          press_valid <= 1'b1;
          press_code  <= rise_code;
        end else if (press_valid && press_ready) begin
          press_valid <= 1'b0;
        end
        if (drop) overrun <= 1'b1;
      end
    end
  end

  assign press_onehot = press_valid ? (4'b0001 << press_code) : 4'b0000;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Randomized bench for simon_button_conditioner, checked every cycle against a
// behavioural model built from the debounce and press-classification rules.
module tb_simon_button_conditioner;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] button;
  logic       clear;
  logic       press_ready;
  logic       press_valid;
  logic [1:0] press_code;
  logic [3:0] press_onehot;
  logic [3:0] held;
  logic       chord_err;
  logic       overrun;

  simon_button_conditioner #(.DEBOUNCE_TICKS(DT), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .button(button),
    .clear(clear),
    .press_ready(press_ready),
    .press_valid(press_valid),
    .press_code(press_code),
    .press_onehot(press_onehot),
    .held(held),
    .chord_err(chord_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model state: two-stage delayed view of the buttons, stable levels, ticks
  // accumulated during the current disagreement, and the pending event queue.
  logic [3:0] m_s1, m_s2, m_held, m_held_prev;
  int         m_run [4];
  int         m_pend [$];
  logic       m_ovr;
  logic       m_chord;

  logic ready_fixed;
  logic clear_fixed;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    m_s1 = '0; m_s2 = '0; m_held = '0; m_held_prev = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_pend.delete();
    m_ovr = 1'b0;
    m_chord = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen just before it.
  task automatic modelEdge();
    logic [3:0] new_press;
    logic [3:0] old_held;
    bit         good;
    int         code;
    if (reset) begin
      modelReset();
      return;
    end
    new_press = m_held & ~m_held_prev;
    good = ($countones(new_press) == 1) && ((m_held & ~new_press) == 4'd0);
    m_chord = (new_press != 4'd0) && !good;
    code = 0;
    for (int i = 0; i < 4; i++) if (new_press[i]) code = i;

    if (clear) begin
      m_pend.delete();
      m_ovr = 1'b0;
    end else begin
      if (m_pend.size() != 0 && press_ready) void'(m_pend.pop_front());
      if (good) begin
        if (m_pend.size() == 0) m_pend.push_back(code);
        else m_ovr = 1'b1;
      end
    end

    old_held = m_held;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_held[i]) begin
        if (tick) begin
          m_run[i]++;
          if (m_run[i] >= DT) begin
            m_held[i] = ~m_held[i];
            m_run[i] = 0;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_held_prev = old_held;
    m_s2 = m_s1;
    m_s1 = button;
  endtask

  task automatic compareAll();
    logic [3:0] exp_onehot;
    exp_onehot = (m_pend.size() != 0) ? (4'b0001 << m_pend[0]) : 4'b0000;
    checkOutput("held", 32'(held), 32'(m_held));
    checkOutput("press_valid", 32'(press_valid), 32'(m_pend.size() != 0));
    if (m_pend.size() != 0) checkOutput("press_code", 32'(press_code), 32'(m_pend[0]));
    checkOutput("press_onehot", 32'(press_onehot), 32'(exp_onehot));
    checkOutput("chord_err", 32'(chord_err), 32'(m_chord));
    checkOutput("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  // Holds a button pattern for n cycles; random mode also randomizes tick,
  // ready and clear, directed mode ticks every cycle.
  task automatic applyStimulus(input logic [3:0] b, input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      button = b;
      if (rnd) begin
        tick        = ($urandom_range(0, 4) != 0);
        press_ready = ($urandom_range(0, 2) == 0);
        clear       = ($urandom_range(0, 30) == 0);
      end else begin
        tick        = 1'b1;
        press_ready = ready_fixed;
        clear       = clear_fixed;
      end
      cycle();
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    applyStimulus(button, 2, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    int         r;
    reset = 1'b1; tick = 1'b0; button = '0; clear = 1'b0; press_ready = 1'b0;
    ready_fixed = 1'b0; clear_fixed = 1'b0;
    #1;
    modelReset();
    compareAll();
    cycle();
    cycle();
    reset = 1'b0;

    // Clean single press, then accepted.
    applyStimulus(4'b0100, 9, 1'b0);
    ready_fixed = 1'b1;
    applyStimulus(4'b0000, 6, 1'b0);
    ready_fixed = 1'b0;
    // Bouncing input never qualifies.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 2, 1'b0);
      applyStimulus(4'b0000, 2, 1'b0);
    end
    applyStimulus(4'b0000, 6, 1'b0);
    // Simultaneous chord, then a rise while another button is held.
    applyStimulus(4'b0011, 10, 1'b0);
    applyStimulus(4'b0000, 10, 1'b0);
    applyStimulus(4'b0001, 10, 1'b0);
    applyStimulus(4'b1001, 10, 1'b0);
    applyStimulus(4'b0000, 10, 1'b0);
    // Overrun with an unconsumed event, then clear.
    applyStimulus(4'b0010, 10, 1'b0);
    applyStimulus(4'b0000, 10, 1'b0);
    applyStimulus(4'b1000, 10, 1'b0);
    clear_fixed = 1'b1;
    applyStimulus(4'b1000, 1, 1'b0);
    clear_fixed = 1'b0;
    applyStimulus(4'b0000, 10, 1'b0);
    // Reset with an event pending and another button mid-debounce.
    applyStimulus(4'b0100, 9, 1'b0);
    applyStimulus(4'b0101, 3, 1'b0);
    button = 4'b0100;
    pulseReset();
    applyStimulus(4'b0100, 10, 1'b0);

    pat = 4'b0000;
    for (int seg = 0; seg < 200; seg++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      pat = 4'b0001 << $urandom_range(0, 3);
      else if (r == 6) pat = 4'b0000;
      else if (r == 7) pat = 4'($urandom_range(0, 15));
      else if (r == 8) pat = pat | (4'b0001 << $urandom_range(0, 3));
      if (r == 9) applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 2), 1'b1);
      else        applyStimulus(pat, $urandom_range(1, 20), 1'b1);
      if ($urandom_range(0, 39) == 0) pulseReset();
    end
    applyStimulus(4'b0000, 10, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
